// File: rtl/clk_pll_pkg.sv
// Shared types and default constants for the PLL lock manager.
package clk_pll_pkg;

  // Lock-manager sequencing states.
  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } pll_state_t;

  localparam int DEF_RST_PULSE    = 16;
  localparam int DEF_LOCK_STABLE  = 1024;
  localparam int DEF_LOCK_TIMEOUT = 65536;
  localparam int DEF_MAX_RETRY    = 3;

  // Width of the retry counter and its saturation value.
  localparam int                 RETRY_W   = 4;
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

endpackage

// File: rtl/clk_ce_div.sv
// One clock-enable channel: shadow divide ratio, phase counter and a
// registered one-cycle strobe. Ratio 0 disables the channel, ratio 1
// strobes every enabled cycle, ratio N strobes on count N-1.
module clk_ce_div #(
  parameter int DIV_W = 16
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [DIV_W-1:0] ratio,
  output logic             ce
);

  logic [DIV_W-1:0] ratio_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] last;
  logic [DIV_W-1:0] cnt_nxt;

  assign last    = ratio_q - DIV_W'(1);
  assign cnt_nxt = (cnt_q == last) ? '0 : cnt_q + DIV_W'(1);

  // Counter and strobe: load realigns the phase, the strobe marks count N-1.
  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      ratio_q <= '0;
      cnt_q   <= '0;
      ce      <= 1'b0;
    end else if (!enable) begin
      cnt_q <= '0;
      ce    <= 1'b0;
    end else if (load) begin
      ratio_q <= ratio;
      cnt_q   <= '0;
      ce      <= (ratio == DIV_W'(1));
    end else if (ratio_q == '0) begin
      cnt_q <= '0;
      ce    <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      ce    <= (cnt_nxt == last);
    end
  end

endmodule

// File: rtl/clk_pll_mgr.sv
// PLL lock manager: sequences the PLL reset, qualifies the synchronised
// lock flag with debounce, timeout and bounded retry, and drives
// NUM_CLKS phase-aligned clock-enable channels once lock is qualified.
module clk_pll_mgr
  import clk_pll_pkg::*;
#(
  parameter int NUM_CLKS     = 2,
  parameter int DIV_W        = 16,
  parameter int RST_PULSE    = DEF_RST_PULSE,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic                      refclk,
  input  logic                      rst_n,
  input  logic                      pll_locked,
  input  logic                      relock_req,
  input  logic                      cfg_load,
  input  logic [NUM_CLKS*DIV_W-1:0] div_cfg,
  output logic                      pll_rst,
  output logic                      clk_ready,
  output logic [NUM_CLKS-1:0]       ce_out,
  output logic                      fault,
  output logic                      lost_lock,
  output logic [RETRY_W-1:0]        retry_cnt
);

  localparam int PULSE_W  = $clog2(RST_PULSE + 1);
  localparam int STABLE_W = $clog2(LOCK_STABLE + 1);
  localparam int TMO_W    = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(RST_PULSE - 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);

  pll_state_t         state_q, state_d;
  logic [1:0]         sync_q;
  logic               lk_s;
  logic [PULSE_W-1:0] pulse_cnt;
  logic [STABLE_W-1:0] stable_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [RETRY_W-1:0] retry_d;
  logic               lost_d;
  logic               pll_rst_d, clk_ready_d, fault_d;
  logic               run_d;
  logic               ch_load;

  // Two-flop lock synchroniser, held clear while the PLL is in reset so a
  // stale lock flag from before the reset pulse can never count as stable.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else if (pll_rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign lk_s = sync_q[1];

  // Next-state, retry and sticky lock-loss logic.
  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    retry_d = retry_cnt;
    lost_d  = lost_lock;
    unique case (state_q)
      ST_RESET: begin
        if (!relock_req && pulse_cnt == PULSE_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (relock_req) begin
          state_d = ST_RESET;
        end else if (lk_s && stable_cnt == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          retry_d = (retry_cnt == RETRY_MAX) ? retry_cnt : retry_cnt + RETRY_W'(1);
          state_d = (retry_d == RETRY_W'(MAX_RETRY)) ? ST_FAULT : ST_RESET;
        end
      end
      ST_RUN: begin
        if (!lk_s || relock_req) state_d = ST_RESET;
      end
      ST_FAULT: begin
        if (relock_req) begin
          state_d = ST_RESET;
          retry_d = '0;
        end
      end
      default: state_d = ST_RESET;
    endcase
    // A lock loss in the same cycle as a relock request leaves the flag set.
    if (relock_req) lost_d = 1'b0;
    if (state_q == ST_RUN && !lk_s) lost_d = 1'b1;
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    pll_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAULT);
    clk_ready_d = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  // State register, sticky status and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      retry_cnt <= '0;
      lost_lock <= 1'b0;
      pll_rst   <= 1'b1;
      clk_ready <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      retry_cnt <= retry_d;
      lost_lock <= lost_d;
      pll_rst   <= pll_rst_d;
      clk_ready <= clk_ready_d;
      fault     <= fault_d;
    end
  end

  // Pulse, stable and timeout counters; each restarts on any state change.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt  <= '0;
      stable_cnt <= '0;
      tmo_cnt    <= '0;
    end else begin
      pulse_cnt  <= (state_q == ST_RESET && state_d == ST_RESET && !relock_req)
                    ? pulse_cnt + PULSE_W'(1) : '0;
      tmo_cnt    <= (state_q == ST_WAIT_LOCK && state_d == ST_WAIT_LOCK)
                    ? tmo_cnt + TMO_W'(1) : '0;
      stable_cnt <= (state_q == ST_WAIT_LOCK && state_d == ST_WAIT_LOCK && lk_s)
                    ? stable_cnt + STABLE_W'(1) : '0;
    end
  end

  // Channels run in the same cycles clk_ready is high; they reload and
  // realign together on RUN entry and on cfg_load while in RUN.
  assign run_d   = (state_d == ST_RUN);
  assign ch_load = run_d && ((state_q != ST_RUN) || cfg_load);

  for (genvar i = 0; i < NUM_CLKS; i++) begin : g_ch
    clk_ce_div #(
      .DIV_W(DIV_W)
    ) u_div (
      .refclk(refclk),
      .rst_n (rst_n),
      .enable(run_d),
      .load  (ch_load),
      .ratio (div_cfg[i*DIV_W +: DIV_W]),
      .ce    (ce_out[i])
    );
  end

endmodule

// File: tb/tb_clk_pll_mgr.sv
// Scoreboard bench for clk_pll_mgr. The stimulus thread pushes the
// hand-computed output vector and cycle of every expected output change;
// the monitor pops one entry each time the observed outputs change.
module tb_clk_pll_mgr;

  localparam int NUM_CLKS = 3;
  localparam int DIV_W    = 8;

  logic                      refclk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      pll_locked = 1'b1;
  logic                      relock_req = 1'b0;
  logic                      cfg_load = 1'b0;
  logic [NUM_CLKS*DIV_W-1:0] div_cfg = '0;
  logic                      pll_rst, clk_ready, fault, lost_lock;
  logic [NUM_CLKS-1:0]       ce_out;
  logic [3:0]                retry_cnt;

  clk_pll_mgr #(
    .NUM_CLKS    (NUM_CLKS),
    .DIV_W       (DIV_W),
    .RST_PULSE   (4),
    .LOCK_STABLE (8),
    .LOCK_TIMEOUT(32),
    .MAX_RETRY   (2)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .cfg_load  (cfg_load),
    .div_cfg   (div_cfg),
    .pll_rst   (pll_rst),
    .clk_ready (clk_ready),
    .ce_out    (ce_out),
    .fault     (fault),
    .lost_lock (lost_lock),
    .retry_cnt (retry_cnt)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic       pr;
    logic       cr;
    logic [2:0] ce;
    logic       f;
    logic       ll;
    logic [3:0] rc;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t v;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   idx    = 0;
  obs_t prev;
  bit   have_prev = 1'b0;

  // Cycle index: value k is seen between posedge k and posedge k+1.
  always @(posedge refclk) cyc <= cyc + 1;

  function automatic string fmt(input obs_t o);
    return $sformatf("pll_rst=%b clk_ready=%b ce_out=%b fault=%b lost_lock=%b retry_cnt=%0d",
                     o.pr, o.cr, o.ce, o.f, o.ll, o.rc);
  endfunction

  task automatic check(input int n, input int got_cyc, input obs_t got, input exp_t want);
    checks++;
    if (got_cyc != want.cyc || got !== want.v) begin
      errors++;
      $display("FAIL trace_%0d: got cycle %0d %s, want cycle %0d %s",
               n, got_cyc, fmt(got), want.cyc, fmt(want.v));
    end
  endtask

  task automatic push_exp(input int c, input logic pr, input logic cr, input logic [2:0] ce,
                          input logic f, input logic ll, input logic [3:0] rc);
    exp_t e;
    e.cyc = c;
    e.v   = {pr, cr, ce, f, ll, rc};
    sb.push_back(e);
  endtask

  // Advance to just after posedge n, where inputs for cycle n are driven.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // Monitor: every change of the output vector consumes one expectation.
  always @(negedge refclk) begin
    obs_t cur;
    exp_t e;
    cur = {pll_rst, clk_ready, ce_out, fault, lost_lock, retry_cnt};
    if (!have_prev || cur !== prev) begin
      idx++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL trace_%0d: got change at cycle %0d to %s, want no change",
                 idx, cyc, fmt(cur));
      end else begin
        e = sb.pop_front();
        check(idx, cyc, cur, e);
      end
      prev      = cur;
      have_prev = 1'b1;
    end
  end

  initial begin
    div_cfg = {8'd3, 8'd1, 8'd0};
    // Reset state.
    push_exp(1, 1, 0, 3'b000, 0, 0, 0);

    // Release reset with lock tied high: 4-cycle PLL reset, ready 10 later,
    // then ratios {0,1,3}: ch1 every cycle, ch2 at run cycles 2,5,8,11.
    goto(3);
    rst_n = 1'b1;
    push_exp(7,  0, 0, 3'b000, 0, 0, 0);
    push_exp(17, 0, 1, 3'b010, 0, 0, 0);
    push_exp(19, 0, 1, 3'b110, 0, 0, 0);
    push_exp(20, 0, 1, 3'b010, 0, 0, 0);
    push_exp(22, 0, 1, 3'b110, 0, 0, 0);
    push_exp(23, 0, 1, 3'b010, 0, 0, 0);
    push_exp(25, 0, 1, 3'b110, 0, 0, 0);
    push_exp(26, 0, 1, 3'b010, 0, 0, 0);
    push_exp(28, 0, 1, 3'b110, 0, 0, 0);
    push_exp(29, 0, 1, 3'b010, 0, 0, 0);

    // Lock drop in RUN, then two timeouts (the second window toggles the
    // lock with 5-cycle highs and 7-cycle highs broken by a glitch) -> FAULT.
    goto(27);
    pll_locked = 1'b0;
    push_exp(30,  1, 0, 3'b000, 0, 1, 0);
    push_exp(34,  0, 0, 3'b000, 0, 1, 0);
    push_exp(66,  1, 0, 3'b000, 0, 1, 1);
    push_exp(70,  0, 0, 3'b000, 0, 1, 1);
    push_exp(102, 1, 0, 3'b000, 1, 1, 2);
    goto(70);  pll_locked = 1'b1;
    goto(75);  pll_locked = 1'b0;
    goto(77);  pll_locked = 1'b1;
    goto(82);  pll_locked = 1'b0;
    goto(83);  pll_locked = 1'b1;
    goto(90);  pll_locked = 1'b0;
    goto(91);  pll_locked = 1'b1;
    goto(98);  pll_locked = 1'b0;
    goto(103); pll_locked = 1'b1;

    // Relock from FAULT clears fault, retry count and lost_lock.
    goto(105);
    relock_req = 1'b1;
    push_exp(106, 1, 0, 3'b000, 0, 0, 0);
    push_exp(110, 0, 0, 3'b000, 0, 0, 0);
    push_exp(120, 0, 1, 3'b010, 0, 0, 0);
    push_exp(122, 0, 1, 3'b110, 0, 0, 0);
    push_exp(123, 0, 1, 3'b010, 0, 0, 0);
    goto(106);
    relock_req = 1'b0;

    // cfg_load 3->2 mid-count, then relock and lock loss in the same cycle.
    goto(124);
    cfg_load = 1'b1;
    div_cfg  = {8'd2, 8'd1, 8'd0};
    push_exp(126, 0, 1, 3'b110, 0, 0, 0);
    push_exp(127, 0, 1, 3'b010, 0, 0, 0);
    push_exp(128, 0, 1, 3'b110, 0, 0, 0);
    push_exp(129, 0, 1, 3'b010, 0, 0, 0);
    push_exp(130, 0, 1, 3'b110, 0, 0, 0);
    push_exp(131, 0, 1, 3'b010, 0, 0, 0);
    push_exp(132, 0, 1, 3'b110, 0, 0, 0);
    push_exp(133, 1, 0, 3'b000, 0, 1, 0);
    push_exp(137, 0, 0, 3'b000, 0, 1, 0);
    goto(125);
    cfg_load = 1'b0;
    goto(130);
    pll_locked = 1'b0;
    goto(132);
    relock_req = 1'b1;
    goto(133);
    relock_req = 1'b0;

    // Asynchronous reset mid-operation returns outputs to reset values.
    goto(140);
    rst_n = 1'b0;
    push_exp(140, 1, 0, 3'b000, 0, 0, 0);

    goto(146);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL trace_end: got %0d expected changes never seen (next at cycle %0d), want 0",
               sb.size(), sb[0].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
